// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: debounces the START/STOP and CLEAR buttons, runs the IDLE/RUN/PAUSE
// FSM and divides the system clock down to the 1 ms enable for the timer counter.
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 160000,
  parameter int DEBOUNCE_CYCLES = 1600000,
  parameter int CNT_W           = 21
) (
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic       I_BTN_START,
  input  logic       I_BTN_CLEAR,
  output logic       O_EN_1MS,
  output logic       O_START_EN,
  output logic       O_CLEAR_EN,
  output logic [1:0] O_STATE
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  // Bit 0 is START/STOP, bit 1 is CLEAR; both buttons share the same conditioning.
  logic [1:0]            btn_raw;
  logic [1:0]            sync1_q;
  logic [1:0]            sync2_q;
  logic [1:0]            deb_q;
  logic [1:0]            deb_d;
  logic [1:0]            deb_dly_q;
  logic [1:0]            armed_q;
  logic [1:0]            armed_d;
  logic [1:0]            press_q;
  logic [1:0][CNT_W-1:0] deb_cnt_q;
  logic [1:0][CNT_W-1:0] deb_cnt_d;

  state_t                state_q;
  logic                  clear_q;
  logic                  tick_q;
  logic [CNT_W-1:0]      presc_q;
  logic                  start_p;
  logic                  clear_p;

  assign btn_raw = {I_BTN_CLEAR, I_BTN_START};

  // Until a button has been seen released for a full debounce window it is not armed,
  // so a button held through reset cannot fire a press when reset drops.
  always_comb begin
    deb_d     = deb_q;
    armed_d   = armed_q;
    deb_cnt_d = deb_cnt_q;
    for (int b = 0; b < 2; b++) begin
      if (!armed_q[b]) begin
        if (sync2_q[b]) begin
          deb_cnt_d[b] = '0;
        end else if (deb_cnt_q[b] == DEB_LAST) begin
          armed_d[b]   = 1'b1;
          deb_cnt_d[b] = '0;
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + CNT_W'(1);
        end
      end else if (sync2_q[b] == deb_q[b]) begin
        deb_cnt_d[b] = '0;
      end else if (deb_cnt_q[b] == DEB_LAST) begin
        deb_d[b]     = sync2_q[b];
        deb_cnt_d[b] = '0;
      end else begin
        deb_cnt_d[b] = deb_cnt_q[b] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      armed_q   <= '0;
      press_q   <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      armed_q   <= armed_d;
      press_q   <= deb_q & ~deb_dly_q;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign start_p = press_q[0];
  assign clear_p = press_q[1];

  // The prescaler holds through PAUSE so resuming keeps the partial millisecond.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q <= IDLE;
      clear_q <= 1'b0;
      tick_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      clear_q <= 1'b0;
      tick_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          presc_q <= '0;
          if (clear_p) begin
            clear_q <= 1'b1;
          end else if (start_p) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (presc_q == TICK_LAST) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
          end else begin
            presc_q <= presc_q + CNT_W'(1);
          end
          if (start_p) begin
            state_q <= PAUSE;
          end
        end
        PAUSE: begin
          if (clear_p) begin
            state_q <= IDLE;
            clear_q <= 1'b1;
            presc_q <= '0;
          end else if (start_p) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= IDLE;
          presc_q <= '0;
        end
      endcase
    end
  end

  assign O_EN_1MS   = tick_q;
  assign O_START_EN = (state_q == RUN);
  assign O_CLEAR_EN = clear_q;
  assign O_STATE    = state_q;

endmodule
